// File: rtl/matrix_op_add_unit.sv
// Element-wise adder C = A + B over two BRAM matrix slots, streamed to the writer into slot 0.
// Optional signed saturating add when MATRIX_OP_ADD_SAT_EN is defined (default: wrap modulo 2^32).
`ifndef MATRIX_DATA_WIDTH
`define MATRIX_DATA_WIDTH 32
`endif
`ifndef MATRIX_ADDR_WIDTH
`define MATRIX_ADDR_WIDTH 9
`endif
`ifndef MATRIX_BLOCK_SIZE
`define MATRIX_BLOCK_SIZE 64
`endif
`ifndef MATRIX_METADATA_WORDS
`define MATRIX_METADATA_WORDS 3
`endif

package matrix_op_defs_pkg;
  localparam int DATA_WIDTH = `MATRIX_DATA_WIDTH;
  localparam int ADDR_WIDTH = `MATRIX_ADDR_WIDTH;
  localparam int BLOCK_SIZE = `MATRIX_BLOCK_SIZE;
  localparam int META       = `MATRIX_METADATA_WORDS;

  typedef enum logic [1:0] {
    MATRIX_OP_STATUS_IDLE    = 2'd0,
    MATRIX_OP_STATUS_SUCCESS = 2'd1,
    MATRIX_OP_STATUS_ERR_ID  = 2'd2,
    MATRIX_OP_STATUS_ERR_DIM = 2'd3
  } matrix_op_status_e;
endpackage

module matrix_op_add_unit
  import matrix_op_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            matrix_a_id,
  input  logic [2:0]            matrix_b_id,
  output logic                  busy,
  output matrix_op_status_e     status,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  write_request,
  input  logic                  write_ready,
  output logic [2:0]            matrix_id,
  output logic [7:0]            actual_rows,
  output logic [7:0]            actual_cols,
  output logic [7:0]            matrix_name [0:7],
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_valid,
  input  logic                  writer_ready,
  input  logic                  write_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_META_A, S_RD_META_B, S_CHECK, S_REQ,
    S_RD_A, S_RD_B, S_SEND, S_WAIT_DONE, S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            a_id_q, a_id_d, b_id_q, b_id_d;
  logic [7:0]            rows_a_q, rows_a_d, cols_a_q, cols_a_d;
  logic [7:0]            rows_b_q, rows_b_d, cols_b_q, cols_b_d;
  logic [7:0]            rows_o_q, rows_o_d, cols_o_q, cols_o_d;
  logic [15:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, dat_q, dat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  vld_q, vld_d, busy_q, busy_d, lat_q, lat_d, name_q, name_d;
  matrix_op_status_e     status_q, status_d;
  logic [15:0]           total;

  localparam logic [7:0] NAME_ADD [0:7] = '{8'h41, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [2:0] id, input logic [15:0] off);
    logic [31:0] s;
    s = 32'(id) * BLOCK_SIZE + 32'(off);
    return s[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] add_op(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [DATA_WIDTH-1:0] y);
`ifdef MATRIX_OP_ADD_SAT_EN
    logic [DATA_WIDTH:0] s;
    s = {x[DATA_WIDTH-1], x} + {y[DATA_WIDTH-1], y};
    // Sign-extended sum disagreeing in its top two bits means signed overflow.
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s[DATA_WIDTH-1:0];
`else
    return x + y;
`endif
  endfunction

  assign total = 16'(rows_a_q) * 16'(cols_a_q);

  always_comb begin
    state_d  = state_q;
    a_id_d   = a_id_q;   b_id_d   = b_id_q;
    rows_a_d = rows_a_q; cols_a_d = cols_a_q;
    rows_b_d = rows_b_q; cols_b_d = cols_b_q;
    rows_o_d = rows_o_q; cols_o_d = cols_o_q;
    idx_d    = idx_q;    a_d      = a_q;
    dat_d    = dat_q;    addr_d   = addr_q;
    vld_d    = vld_q;    busy_d   = busy_q;
    lat_d    = 1'b0;     name_d   = name_q;
    status_d = status_q;
    // Every read state spends one cycle waiting on BRAM latency (lat_q low), then consumes data_out.
    case (state_q)
      S_IDLE: if (start) begin
        a_id_d  = matrix_a_id;
        b_id_d  = matrix_b_id;
        busy_d  = 1'b1;
        addr_d  = slot_addr(matrix_a_id, 16'd0);
        state_d = S_RD_META_A;
      end
      S_RD_META_A: if (!lat_q) lat_d = 1'b1;
      else begin
        rows_a_d = data_out[31:24];
        cols_a_d = data_out[23:16];
        addr_d   = slot_addr(b_id_q, 16'd0);
        state_d  = S_RD_META_B;
      end
      S_RD_META_B: if (!lat_q) lat_d = 1'b1;
      else begin
        rows_b_d = data_out[31:24];
        cols_b_d = data_out[23:16];
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (a_id_q == 3'd0 || b_id_q == 3'd0) begin
          status_d = MATRIX_OP_STATUS_ERR_ID;
          state_d  = S_FINISH;
        end else if (rows_a_q != rows_b_q || cols_a_q != cols_b_q ||
                     rows_a_q == 8'd0 || cols_a_q == 8'd0) begin
          status_d = MATRIX_OP_STATUS_ERR_DIM;
          state_d  = S_FINISH;
        end else begin
          rows_o_d = rows_a_q;
          cols_o_d = cols_a_q;
          name_d   = 1'b1;
          idx_d    = 16'd0;
          state_d  = S_REQ;
        end
      end
      S_REQ: if (write_ready) begin
        addr_d  = slot_addr(a_id_q, 16'(META));
        state_d = S_RD_A;
      end
      S_RD_A: if (!lat_q) lat_d = 1'b1;
      else begin
        a_d     = data_out;
        addr_d  = slot_addr(b_id_q, idx_q + 16'(META));
        state_d = S_RD_B;
      end
      S_RD_B: if (!lat_q) lat_d = 1'b1;
      else begin
        dat_d   = add_op(a_q, data_out);
        vld_d   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: if (writer_ready) begin
        vld_d = 1'b0;
        idx_d = idx_q + 16'd1;
        if (idx_q + 16'd1 == total) state_d = S_WAIT_DONE;
        else begin
          addr_d  = slot_addr(a_id_q, idx_q + 16'd1 + 16'(META));
          state_d = S_RD_A;
        end
      end
      S_WAIT_DONE: if (write_done) begin
        status_d = MATRIX_OP_STATUS_SUCCESS;
        state_d  = S_FINISH;
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_id_q   <= '0; b_id_q   <= '0;
      rows_a_q <= '0; cols_a_q <= '0;
      rows_b_q <= '0; cols_b_q <= '0;
      rows_o_q <= '0; cols_o_q <= '0;
      idx_q    <= '0; a_q      <= '0;
      dat_q    <= '0; addr_q   <= '0;
      vld_q    <= 1'b0; busy_q <= 1'b0;
      lat_q    <= 1'b0; name_q <= 1'b0;
      status_q <= MATRIX_OP_STATUS_IDLE;
    end else begin
      state_q  <= state_d;
      a_id_q   <= a_id_d;   b_id_q   <= b_id_d;
      rows_a_q <= rows_a_d; cols_a_q <= cols_a_d;
      rows_b_q <= rows_b_d; cols_b_q <= cols_b_d;
      rows_o_q <= rows_o_d; cols_o_q <= cols_o_d;
      idx_q    <= idx_d;    a_q      <= a_d;
      dat_q    <= dat_d;    addr_q   <= addr_d;
      vld_q    <= vld_d;    busy_q   <= busy_d;
      lat_q    <= lat_d;    name_q   <= name_d;
      status_q <= status_d;
    end
  end

  assign busy          = busy_q;
  assign status        = status_q;
  assign read_addr     = addr_q;
  assign write_request = (state_q == S_REQ);
  assign matrix_id     = 3'd0;
  assign actual_rows   = rows_o_q;
  assign actual_cols   = cols_o_q;
  assign data_in       = dat_q;
  assign data_valid    = vld_q;

  always_comb begin
    for (int k = 0; k < 8; k++) matrix_name[k] = name_q ? NAME_ADD[k] : 8'h00;
  end

endmodule

// File: tb/tb_matrix_op_add_unit.sv
// Scoreboarded bench for matrix_op_add_unit: BRAM and writer models, queue-based element checking.
module tb_matrix_op_add_unit;
  import matrix_op_defs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, start;
  logic [2:0]            matrix_a_id, matrix_b_id;
  logic                  busy;
  matrix_op_status_e     status;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  write_request, write_ready;
  logic [2:0]            matrix_id;
  logic [7:0]            actual_rows, actual_cols;
  logic [7:0]            matrix_name [0:7];
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid, writer_ready, write_done;

  matrix_op_add_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .matrix_a_id(matrix_a_id), .matrix_b_id(matrix_b_id),
    .busy(busy), .status(status), .read_addr(read_addr), .data_out(data_out),
    .write_request(write_request), .write_ready(write_ready), .matrix_id(matrix_id),
    .actual_rows(actual_rows), .actual_cols(actual_cols), .matrix_name(matrix_name),
    .data_in(data_in), .data_valid(data_valid), .writer_ready(writer_ready),
    .write_done(write_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // BRAM: slots 1..7 live here; slot 0 is owned by the writer model.
  logic [31:0] mem [0:8*BLOCK_SIZE-1];
  always @(posedge clk) data_out <= mem[read_addr];

  function automatic int waddr(input int id, input int i);
    return id * BLOCK_SIZE + META + i;
  endfunction

  // Writer model, sampled on the falling edge so every input it sees is settled.
  logic [31:0] slot0 [0:BLOCK_SIZE-1];
  int acc_cnt = 0, exp_total = 0, done_cnt = 0, req_cnt = 0;
  logic [7:0] name_exp [0:7] = '{8'h41, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < BLOCK_SIZE; k++) slot0[k] = 32'hDEAD0000 + k;
      acc_cnt = 0; done_cnt = 0; write_done = 1'b0;
    end else begin
      write_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) write_done = 1'b1;
      end
      if (write_request && write_ready) begin
        req_cnt++;
        acc_cnt   = 0;
        exp_total = actual_rows * actual_cols;
        check("hdr_matrix_id", matrix_id, 0);
        for (int k = 0; k < 8; k++) check($sformatf("hdr_name%0d", k), matrix_name[k], name_exp[k]);
        slot0[0] = {actual_rows, actual_cols, 16'h0};
        slot0[1] = {matrix_name[0], matrix_name[1], matrix_name[2], matrix_name[3]};
        slot0[2] = {matrix_name[4], matrix_name[5], matrix_name[6], matrix_name[7]};
      end
      if (data_valid && writer_ready) begin
        if (META + acc_cnt < BLOCK_SIZE) slot0[META + acc_cnt] = data_in;
        acc_cnt++;
        if (acc_cnt == exp_total) done_cnt = 3;
      end
    end
  end

  // Scoreboard monitor: pops the expected sum for every accepted element.
  logic [31:0] exp_q [$];
  logic        held_vld = 1'b0;
  logic [31:0] held_dat;

  always @(negedge clk) begin
    if (!rst_n) held_vld = 1'b0;
    else if (data_valid) begin
      if (held_vld) check("data_in_hold", data_in, held_dat);
      if (writer_ready) begin
        if (exp_q.size() == 0) check("extra_element", 1, 0);
        else check("element", data_in, exp_q.pop_front());
        held_vld = 1'b0;
      end else begin
        held_vld = 1'b1;
        held_dat = data_in;
      end
    end else begin
      if (held_vld) check("valid_dropped_unaccepted", 0, 1);
      held_vld = 1'b0;
    end
  end

  // Ready drivers, updated just after the rising edge.
  logic rand_ready = 1'b0, stall_mode = 1'b0, stall_fired = 1'b0;
  int   stall_left = 0, stall_seen = 0;
  always @(posedge clk) begin
    #1;
    if (!busy) stall_fired = 1'b0;
    if (stall_mode && !stall_fired && acc_cnt == 2 && data_valid) begin
      stall_fired = 1'b1;
      stall_left  = 3;
    end
    if (stall_left > 0) begin
      writer_ready = 1'b0;
      stall_left--;
      stall_seen++;
    end else writer_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
    write_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
  end

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
`ifdef MATRIX_OP_ADD_SAT_EN
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
`else
    return x + y;
`endif
  endfunction

  task automatic load_hdr(input int id, input int r, input int c);
    mem[id * BLOCK_SIZE]     = {r[7:0], c[7:0], 16'h0};
    mem[id * BLOCK_SIZE + 1] = 32'h0;
    mem[id * BLOCK_SIZE + 2] = 32'h0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input bit second_start);
    matrix_op_status_e est;
    logic [7:0]  ra, ca, rb, cb;
    logic [31:0] snap [0:BLOCK_SIZE-1];
    logic [31:0] exp_res [0:BLOCK_SIZE-1];
    int total, req0, cyc;
    ra = mem[a * BLOCK_SIZE][31:24]; ca = mem[a * BLOCK_SIZE][23:16];
    rb = mem[b * BLOCK_SIZE][31:24]; cb = mem[b * BLOCK_SIZE][23:16];
    if (a == 0 || b == 0) est = MATRIX_OP_STATUS_ERR_ID;
    else if (ra != rb || ca != cb || ra == 0 || ca == 0) est = MATRIX_OP_STATUS_ERR_DIM;
    else est = MATRIX_OP_STATUS_SUCCESS;
    total = (est == MATRIX_OP_STATUS_SUCCESS) ? ra * ca : 0;
    for (int i = 0; i < total; i++) begin
      exp_res[i] = ref_add(mem[waddr(a, i)], mem[waddr(b, i)]);
      exp_q.push_back(exp_res[i]);
    end
    snap = slot0;
    req0 = req_cnt;
    @(negedge clk);
    start = 1'b1; matrix_a_id = a; matrix_b_id = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (second_start && cyc == 2) begin start = 1'b1; matrix_a_id = 3'd3; matrix_b_id = 3'd1; end
      if (cyc == 3) start = 1'b0;
    end
    if (busy) check({tag, "_timeout"}, 0, 1);
    check({tag, "_status"}, status, est);
    check({tag, "_busy_min2"}, (cyc + 1 >= 2), 1);
    check({tag, "_write_requests"}, req_cnt - req0, (est == MATRIX_OP_STATUS_SUCCESS) ? 1 : 0);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
    if (est == MATRIX_OP_STATUS_SUCCESS) begin
      check({tag, "_word0"}, slot0[0], {ra, ca, 16'h0});
      check({tag, "_word1"}, slot0[1], 32'h41444400);
      check({tag, "_word2"}, slot0[2], 32'h0);
      for (int i = 0; i < total; i++) check($sformatf("%s_c%0d", tag, i), slot0[META + i], exp_res[i]);
    end else begin
      for (int i = 0; i < META + 4; i++) check($sformatf("%s_slot0_kept%0d", tag, i), slot0[i], snap[i]);
    end
  endtask

  initial begin
    int r, c, cb;
    rst_n = 1'b0; start = 1'b0; matrix_a_id = 3'd0; matrix_b_id = 3'd0;
    writer_ready = 1'b1; write_ready = 1'b1;
    for (int k = 0; k < 8 * BLOCK_SIZE; k++) mem[k] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_status", status, MATRIX_OP_STATUS_IDLE);
    check("rst_read_addr", read_addr, 0);
    check("rst_write_request", write_request, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_in", data_in, 0);
    check("rst_matrix_id", matrix_id, 0);
    check("rst_rows", actual_rows, 0);
    check("rst_cols", actual_cols, 0);
    check("rst_name0", matrix_name[0], 0);
    rst_n = 1'b1;

    load_hdr(1, 2, 2); load_hdr(2, 2, 2); load_hdr(3, 2, 3); load_hdr(4, 2, 2);
    for (int i = 0; i < 4; i++) begin
      mem[waddr(1, i)] = i + 1;
      mem[waddr(2, i)] = 10 * (i + 1);
      mem[waddr(4, i)] = 2 * (i + 1);
    end
    for (int i = 0; i < 6; i++) mem[waddr(3, i)] = 100 + i;

    run_op("add12", 3'd1, 3'd2, 1'b0);
    check("add12_word0_const", slot0[0], 32'h02020000);
    check("add12_c3_const", slot0[META + 3], 32'd44);
    run_op("add14", 3'd1, 3'd4, 1'b0);
    check("add14_c0_const", slot0[META], 32'd3);
    run_op("dim13", 3'd1, 3'd3, 1'b0);
    check("dim13_status_const", status, MATRIX_OP_STATUS_ERR_DIM);
    run_op("id02", 3'd0, 3'd2, 1'b0);
    check("id02_status_const", status, MATRIX_OP_STATUS_ERR_ID);

    load_hdr(5, 1, 1); load_hdr(6, 1, 1);
`ifdef MATRIX_OP_ADD_SAT_EN
    mem[waddr(5, 0)] = 32'h7FFFFFFF;
`else
    mem[waddr(5, 0)] = 32'hFFFFFFFF;
`endif
    mem[waddr(6, 0)] = 32'h1;
    run_op("ovf", 3'd5, 3'd6, 1'b0);
`ifdef MATRIX_OP_ADD_SAT_EN
    check("ovf_sat_const", slot0[META], 32'h7FFFFFFF);
`else
    check("ovf_wrap_const", slot0[META], 32'h0);
`endif

    stall_mode = 1'b1;
    stall_seen = 0;
    run_op("stall", 3'd2, 3'd4, 1'b1);
    stall_mode = 1'b0;
    check("stall_applied", stall_seen, 3);

    rand_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      r  = $urandom_range(6);
      c  = $urandom_range(8, 1);
      cb = ($urandom_range(3) == 0) ? c + 1 : c;
      load_hdr(5, r, c); load_hdr(6, r, cb);
      for (int i = 0; i < 54; i++) begin
        mem[waddr(5, i)] = $urandom;
        mem[waddr(6, i)] = ($urandom_range(3) == 0) ? 32'h7FFFFFF0 + $urandom_range(31) : $urandom;
      end
      run_op($sformatf("rnd%0d", t), 3'd5, 3'd6, 1'b0);
    end
    rand_ready = 1'b0;

    @(negedge clk);
    start = 1'b1; matrix_a_id = 3'd1; matrix_b_id = 3'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_write_request", write_request, 0);
    check("arst_data_valid", data_valid, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 3'd1, 3'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
